// File: rtl/mem_stage.sv
// RV32I data-memory stage: byte/half/word loads and stores against an internal word RAM,
// with a configurable wait-state counter that stalls the pipeline while an access is pending.
module mem_stage #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] mem_res_o,
  output logic        stall_o,
  output logic        fault_o
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [IdxW-1:0] idx;
  logic            req, bad, start_wait, complete, we;
  logic [3:0]      be;
  logic [31:0]     wdata_lane, rdata;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic            unused_addr;

  assign idx         = addr_i[IdxW+1:2];
  assign unused_addr = ^addr_i[31:IdxW+2];
  assign req         = mem_rd_i | mem_wr_i;

  // Illegal width code, misalignment, or an unsigned width on a store.
  always_comb begin
    bad = 1'b0;
    unique case (funct3_i)
      3'b000:  bad = 1'b0;
      3'b001:  bad = addr_i[0];
      3'b010:  bad = addr_i[1:0] != 2'b00;
      3'b100:  bad = mem_wr_i;
      3'b101:  bad = mem_wr_i | addr_i[0];
      default: bad = 1'b1;
    endcase
  end

  assign fault_o    = req & bad;
  assign start_wait = (state_q == StIdle) & req & ~bad & (LATENCY != 0);
  assign complete   = ((state_q == StIdle) & req & ~bad & (LATENCY == 0)) |
                      ((state_q == StBusy) & (cnt_q == 4'd0));
  assign stall_o    = start_wait | ((state_q == StBusy) & (cnt_q != 4'd0));
  assign we         = complete & mem_wr_i & ~rst_i;

  always_comb begin
    be         = 4'b0000;
    wdata_lane = wdata_i;
    unique case (funct3_i[1:0])
      2'b00: begin
        be         = 4'b0001 << addr_i[1:0];
        wdata_lane = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be         = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata_i[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[idx];
  assign rhalf = addr_i[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    rbyte = rdata[7:0];
    unique case (addr_i[1:0])
      2'b00: rbyte = rdata[7:0];
      2'b01: rbyte = rdata[15:8];
      2'b10: rbyte = rdata[23:16];
      2'b11: rbyte = rdata[31:24];
    endcase
  end

  // A simultaneous read and write is a store, so it never returns data.
  always_comb begin
    mem_res_o = '0;
    if (complete & mem_rd_i & ~mem_wr_i) begin
      unique case (funct3_i)
        3'b000:  mem_res_o = {{24{rbyte[7]}}, rbyte};
        3'b001:  mem_res_o = {{16{rhalf[15]}}, rhalf};
        3'b010:  mem_res_o = rdata;
        3'b100:  mem_res_o = {24'd0, rbyte};
        3'b101:  mem_res_o = {16'd0, rhalf};
        default: mem_res_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_wait) begin
            state_q <= StBusy;
            cnt_q   <= 4'(LATENCY - 1);
          end
        end
        StBusy: begin
          if (cnt_q == 4'd0) state_q <= StIdle;
          else cnt_q <= cnt_q - 4'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: two instances (no wait states and three wait states)
// driven by directed and random accesses, checked against a byte-array memory model.
module tb_mem_stage;

  typedef struct {
    logic [31:0] res;
    logic        flt;
    int          stalls;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd     [2];
  logic        wr     [2];
  logic [2:0]  f3     [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [31:0] res    [2];
  logic        stall  [2];
  logic        flt    [2];

  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] mdl [2][4096];
  int stall_cnt [2];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .mem_rd_i(rd[0]), .mem_wr_i(wr[0]), .funct3_i(f3[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .mem_res_o(res[0]), .stall_o(stall[0]),
    .fault_o(flt[0])
  );

  mem_stage #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .mem_rd_i(rd[1]), .mem_wr_i(wr[1]), .funct3_i(f3[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .mem_res_o(res[1]), .stall_o(stall[1]),
    .fault_o(flt[1])
  );

  task automatic check(input string name, input int d, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %h, expected %h", name, d, $time, got, exp);
    end
  endtask

  // Reference model: legality from the width/alignment rules, memory as a flat byte array.
  function automatic bit model_fault(input bit store, input logic [2:0] f, input logic [31:0] a);
    case (f)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return a[1:0] != 2'b00;
      3'b100:  return store;
      3'b101:  return store || a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input int d, input logic [2:0] f,
                                             input logic [31:0] a);
    int b = int'(a % 4096);
    int w = b - (b % 4);
    logic [7:0]  by = mdl[d][b];
    logic [15:0] hw = {mdl[d][b+1], mdl[d][b]};
    case (f)
      3'b000:  return {{24{by[7]}}, by};
      3'b001:  return {{16{hw[15]}}, hw};
      3'b010:  return {mdl[d][w+3], mdl[d][w+2], mdl[d][w+1], mdl[d][w]};
      3'b100:  return {24'd0, by};
      default: return {16'd0, hw};
    endcase
  endfunction

  function automatic void model_store(input int d, input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] v);
    int b = int'(a % 4096);
    int nbytes = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    for (int i = 0; i < nbytes; i++) mdl[d][b+i] = v[8*i +: 8];
  endfunction

  task automatic access(input int d, input bit r, input bit w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] v);
    exp_t e;
    int lat = (d == 0) ? 0 : 3;
    e.flt    = model_fault(w, f, a);
    e.stalls = e.flt ? 0 : lat;
    e.res    = (!e.flt && r && !w) ? model_load(d, f, a) : 32'd0;
    if (!e.flt && w) model_store(d, f, a, v);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    rd[d] = r; wr[d] = w; f3[d] = f; addr[d] = a; wdata[d] = v;
    repeat (e.flt ? 1 : lat + 1) @(posedge clk);
    #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic monitor(input int d);
    exp_t e;
    if (rst) begin
      stall_cnt[d] = 0;
    end else if (rd[d] || wr[d]) begin
      if (stall[d]) begin
        stall_cnt[d]++;
      end else begin
        checks++;
        if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
          errors++;
          $display("FAIL unexpected_completion dut%0d @%0t: got a completion, expected none",
                   d, $time);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check("mem_res", d, res[d], e.res);
          check("fault", d, 32'(flt[d]), 32'(e.flt));
          check("stall_cycles", d, stall_cnt[d], e.stalls);
        end
        stall_cnt[d] = 0;
      end
    end else begin
      check("idle_outputs", d, {res[d] | 32'(stall[d]) | 32'(flt[d])}, 32'd0);
    end
  endtask

  always @(negedge clk) monitor(0);
  always @(negedge clk) monitor(1);

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; f3[d] = 3'b000; addr[d] = '0; wdata[d] = '0;
      stall_cnt[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Word store/load, byte lanes, extension and faults with no wait states.
    access(0, 1, 0, 3'b010, 32'h0000_0010, 32'h0);  // warm-up read, expectation discarded
    q0.delete();
    access(0, 0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    access(0, 1, 0, 3'b010, 32'h10, 32'h0);
    access(0, 0, 1, 3'b000, 32'h13, 32'h0000_0080);
    access(0, 1, 0, 3'b000, 32'h13, 32'h0);
    access(0, 1, 0, 3'b100, 32'h13, 32'h0);
    access(0, 1, 0, 3'b010, 32'h10, 32'h0);
    access(0, 0, 1, 3'b001, 32'h10, 32'h0000_1234);
    access(0, 1, 0, 3'b010, 32'h10, 32'h0);
    access(0, 1, 0, 3'b101, 32'h12, 32'h0);
    access(0, 1, 0, 3'b001, 32'h11, 32'h0);
    access(0, 0, 1, 3'b010, 32'h12, 32'hFFFF_FFFF);
    access(0, 1, 0, 3'b010, 32'h10, 32'h0);
    access(0, 1, 0, 3'b011, 32'h10, 32'h0);
    access(0, 0, 1, 3'b100, 32'h10, 32'h0000_00AA);
    access(0, 1, 1, 3'b010, 32'h40, 32'h1357_9BDF);
    access(0, 1, 0, 3'b010, 32'h40, 32'h0);
    access(0, 0, 1, 3'b010, 32'h1000, 32'hCAFE_F00D);
    access(0, 1, 0, 3'b010, 32'h0, 32'h0);
    idle(1);

    // Three wait states: single load, back-to-back store/load, reset abort.
    access(1, 0, 1, 3'b010, 32'h10, 32'h80AD_1234);
    idle(1);
    access(1, 1, 0, 3'b010, 32'h10, 32'h0);
    access(1, 0, 1, 3'b010, 32'h24, 32'h2468_ACE0);
    access(1, 1, 0, 3'b010, 32'h24, 32'h0);
    access(1, 0, 1, 3'b010, 32'h20, 32'h5555_5555);
    idle(1);
    rd[1] = 1'b0; wr[1] = 1'b1; f3[1] = 3'b010; addr[1] = 32'h20; wdata[1] = 32'h1111_1111;
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    wr[1] = 1'b0;
    @(negedge clk);
    check("stall_after_abort", 1, 32'(stall[1]), 32'd0);
    idle(1);
    access(1, 1, 0, 3'b010, 32'h20, 32'h0);

    // Random traffic over a pre-initialised window, with aliased upper address bits.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) access(d, 0, 1, 3'b010, 32'h100 + 32'(4 * i), $urandom);
      for (int i = 0; i < 120; i++) begin
        int kind = int'($urandom_range(0, 9));
        logic [31:0] a = 32'h100 + 32'($urandom_range(0, 63)) +
                         32'h1000 * 32'($urandom_range(0, 7));
        logic [2:0] f = 3'($urandom_range(0, 7));
        if (kind == 0) idle(1);
        else if (kind < 5) access(d, 1, 0, f, a, 32'h0);
        else if (kind < 9) access(d, 0, 1, f, a, $urandom);
        else access(d, 1, 1, f, a, $urandom);
      end
    end

    idle(3);
    check("q0_drained", 0, 32'(q0.size()), 32'd0);
    check("q1_drained", 1, 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Data-memory stage of the RV32I pipeline, between the EX/MEM register and the MEM/WB register. It executes loads and stores (byte/half/word, signed/unsigned) against an internal word-organised data RAM, and delivers the extended load result on `mem_res`, which feeds MEM/WB `mem_res_in`. It models a slow memory with a configurable wait-state counter and asserts `stall` while an access is outstanding. The pipeline control drives the MEM/WB `enable` from `~stall`.

## Interface
- `DEPTH_WORDS`, default 1024. Number of 32-bit RAM words; must be a power of two.
- `LATENCY`, default 0. Wait states per access, range 0..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_rd`  in  1  load request.
- `mem_wr`  in  1  store request.
- `funct3`  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  32  byte address, which is the ALU result.
- `wdata`  in  32  store data, taken from the low bits.
- `mem_res`  out  32  extended load data.
- `stall`  out  1  access in progress; upstream holds its inputs and MEM/WB is frozen.
- `fault`  out  1  misaligned access or illegal `funct3` on a request.

## Operation
- **RAM index:** `addr[log2(DEPTH_WORDS)+1:2]`. Higher address bits are ignored, so out-of-range addresses wrap.
- **RAM contents:** not cleared by reset.
- **Request:** `mem_rd | mem_wr`. If both are high, the access is treated as a store and `mem_res` = 0.
- **Fault conditions:**
  - H/HU with `addr[0]` = 1.
  - W with `addr[1:0]` ≠ 0.
  - `funct3` ∈ {011, 110, 111}.
  - Loads with `funct3` 100/101 are legal; stores with 100/101 are illegal.
- **Fault behaviour:** `fault` = 1 combinationally in the request cycle, no RAM write, `mem_res` = 0, `stall` = 0, FSM stays IDLE.
- **Store byte enables:**
  - SB writes lane `addr[1:0]` with `wdata[7:0]`.
  - SH writes lanes {1,0} or {3,2} with `wdata[15:0]`.
  - SW writes all four lanes.
- **Load extraction:** pick the byte or halfword at `addr[1:0]`. B/H sign-extend; BU/HU zero-extend; W passes the word through.
- **`mem_res` outside a completing load:** 0.
- **FSM states:** IDLE and BUSY, plus a 4-bit wait counter `cnt`.
- **IDLE:**
  - No request, or a faulting request: stay IDLE.
  - Legal request with `LATENCY` = 0: the access completes this cycle.
  - Legal request with `LATENCY` > 0: `stall` = 1, `cnt` ← `LATENCY` − 1, next state BUSY.
- **BUSY:**
  - `cnt` ≠ 0: `stall` = 1 and `cnt` decrements.
  - `cnt` = 0: completion cycle.
- **Completion cycle:**
  - `stall` = 0.
  - A load presents `mem_res` from the current RAM contents.
  - A store commits at the closing clock edge.
  - Next state IDLE.
- **Request held high after completion:** treated as a new access, because the pipeline has advanced.
- **Reset mid-access:** abort. No write commits, state goes to IDLE, `cnt` = 0.

## Timing
- **Reset values:** `stall` = 0, `fault` = 0, `mem_res` = 0 (no request is pending after reset), state IDLE.
- **Access length:** `LATENCY` + 1 cycles. `stall` is high for exactly the first `LATENCY` of them; it is combinational in the request cycle and registered-state-driven afterwards.
- **Load data:** valid combinationally in the completion cycle and captured by MEM/WB on that cycle's rising edge.
- **Store visibility:** a store is visible to a load issued in the following cycle. There is no read-during-write bypass within the same cycle, because only one access exists per cycle.
- **Input stability:** `addr`, `wdata`, `funct3`, `mem_rd`, `mem_wr` must be stable while `stall` = 1. Changes during stall are undefined, and the bench must not do this.
- **Fault timing:** `fault` is combinational and never extends an access.

## Test plan
- **Word store/load:** `LATENCY`=0. SW `0xDEADBEEF` @`0x10`, then LW @`0x10` → `mem_res`=`0xDEADBEEF`, `stall` never high.
- **Byte lanes and extension:** after the above, SB `0x80` @`0x13`.
  - LB @`0x13` → `0xFFFFFF80`.
  - LBU @`0x13` → `0x00000080`.
  - LW @`0x10` → `0x80ADBEEF`.
  - SH `0x1234` @`0x10`, then LW @`0x10` → `0x80AD1234`.
  - LHU @`0x12` → `0x000080AD`.
- **Faults:**
  - LH @`0x11` → `fault`=1, `mem_res`=0, `stall`=0.
  - SW `0xFFFFFFFF` @`0x12` → `fault`=1; LW @`0x10` is still `0x80AD1234`.
  - `funct3`=011 → `fault`=1.
- **Wait states:** `LATENCY`=3. LW @`0x10` → `stall`=1 for cycles 0–2, `stall`=0 with `mem_res`=`0x80AD1234` in cycle 3. Back-to-back SW then LW → 8 total cycles, and the LW returns the stored value.
- **Reset mid-access:** `LATENCY`=3. SW `0x11111111` @`0x20`, assert `rst` in cycle 1 → `stall`=0 next cycle. A subsequent LW @`0x20` returns the prior contents, not `0x11111111`.
- **Address wrap:** `DEPTH_WORDS`=1024. SW `0xCAFEF00D` @`0x1000`, then LW @`0x0` → `0xCAFEF00D`.
